// File: rtl/skid_fifo_pkg.sv
// rtl/skid_fifo_pkg.sv - shared constants and sizing helper for the skid_fifo elastic buffer
package skid_fifo_pkg;

    // Default word width for the UART/ALU byte path.
    localparam int SKID_DEF_WIDTH = 8;

    function automatic int skid_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_fifo_mem.sv
// rtl/skid_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one asynchronous read port
module skid_fifo_mem
    import skid_fifo_pkg::*;
#(
    parameter int WIDTH = SKID_DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int AW    = skid_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is deliberately left unreset; the pointer/count logic masks stale entries.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/skid_fifo.sv
// rtl/skid_fifo.sv - full-throughput elastic buffer with occupancy count, flush and almost-full flag
module skid_fifo
    import skid_fifo_pkg::*;
#(
    parameter int WIDTH     = SKID_DEF_WIDTH,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [skid_clog2(DEPTH):0] count,
    output logic                       almost_full
);

    localparam int AW = skid_clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // ready_in looks only at registered count so there is no path from ready_out.
    assign ready_in    = (count != CW'(DEPTH));
    assign valid_out   = (count != '0);
    assign almost_full = (count >= CW'(AFULL_LVL));
    assign push        = valid_in & ready_in;
    assign pop         = valid_out & ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    skid_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_skid_fifo.sv
// tb/tb_skid_fifo.sv - randomized self-checking bench for skid_fifo against a queue reference model
module tb_skid_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = DEPTH - 1;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] data_i;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] data_o;
    logic             valid_out;
    logic             ready_out;
    logic [CW-1:0]    count;
    logic             almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q [$];

    always #5 clk = ~clk;

    skid_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .data_i      (data_i),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_o      (data_o),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every output against what the queue says the buffer should present.
    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        check_eq({tag, ".count"}, 32'(count), 32'(sz));
        check_eq({tag, ".valid_out"}, 32'(valid_out), 32'(sz != 0));
        check_eq({tag, ".ready_in"}, 32'(ready_in), 32'(sz != DEPTH));
        check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AFULL_LVL));
        if (sz != 0) begin
            check_eq({tag, ".data_o"}, 32'(data_o), 32'(model_q[0]));
        end
    endtask

    // Drive one cycle of inputs, check present outputs, then advance the model across the edge.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                        input logic r, input logic f);
        bit do_push;
        bit do_pop;
        valid_in  = v;
        data_i    = d;
        ready_out = r;
        flush     = f;
        check_outputs(tag);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
    endtask

    initial begin
        logic             hold_v;
        logic [WIDTH-1:0] hold_d;
        logic             rv;
        logic             rr;
        logic             rf;
        logic [WIDTH-1:0] rd;

        rst = 1'b1; flush = 1'b0; data_i = '0; valid_in = 1'b0; ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with three entries held.
        step("pre_rst", 1'b1, 8'h01, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 8'h02, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 8'h03, 1'b0, 1'b0);
        check_eq("pre_rst.count3", 32'(count), 32'd3);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        check_eq("async_rst.valid_out", 32'(valid_out), 32'd0);
        check_eq("async_rst.ready_in", 32'(ready_in), 32'd1);
        check_eq("async_rst.count", 32'(count), 32'd0);
        check_eq("async_rst.almost_full", 32'(almost_full), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("post_rst.data_o", 32'(data_o), 32'hA5);
        check_eq("post_rst.valid_out", 32'(valid_out), 32'd1);
        step("post_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full with no downstream ready, then try a fifth word.
        step("fill", 1'b1, 8'h11, 1'b0, 1'b0);
        step("fill", 1'b1, 8'h22, 1'b0, 1'b0);
        check_eq("fill.afull_at2", 32'(almost_full), 32'd0);
        step("fill", 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("fill.afull_at3", 32'(almost_full), 32'd1);
        step("fill", 1'b1, 8'h44, 1'b0, 1'b0);
        check_eq("full.count", 32'(count), 32'd4);
        check_eq("full.ready_in", 32'(ready_in), 32'd0);
        step("full_reject", 1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("full_reject.count", 32'(count), 32'd4);
        // Pop while full with valid_in high: only the pop may happen.
        step("full_pop", 1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("full_pop.count", 32'(count), 32'd3);
        check_eq("full_pop.data_o", 32'(data_o), 32'h22);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("drain.valid_out", 32'(valid_out), 32'd0);

        // Full-rate streaming across many pointer wraps.
        for (int i = 0; i < 64; i++) begin
            step("stream", 1'b1, 8'(i), 1'b1, 1'b0);
            check_eq("stream.count", 32'(count), 32'd1);
            check_eq("stream.data_o", 32'(data_o), 32'(i));
        end
        // Simultaneous push/pop at count=1.
        step("cnt1", 1'b1, 8'h77, 1'b1, 1'b0);
        check_eq("cnt1.count", 32'(count), 32'd1);
        check_eq("cnt1.data_o", 32'(data_o), 32'h77);
        step("cnt1_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush wins over a simultaneous push and pop.
        step("flush_setup", 1'b1, 8'hB0, 1'b0, 1'b0);
        step("flush_setup", 1'b1, 8'hB1, 1'b0, 1'b0);
        step("flush", 1'b1, 8'hC0, 1'b1, 1'b1);
        check_eq("flush.count", 32'(count), 32'd0);
        check_eq("flush.valid_out", 32'(valid_out), 32'd0);
        check_eq("flush.ready_in", 32'(ready_in), 32'd1);
        step("post_flush", 1'b1, 8'hD0, 1'b0, 1'b0);
        check_eq("post_flush.data_o", 32'(data_o), 32'hD0);
        check_eq("post_flush.count", 32'(count), 32'd1);

        // Random traffic; upstream holds its word while stalled.
        hold_v = 1'b0;
        hold_d = '0;
        for (int i = 0; i < 10000; i++) begin
            rr = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 199) == 0);
            if (hold_v) begin
                rv = 1'b1;
                rd = hold_d;
            end else begin
                rv = 1'($urandom_range(0, 1));
                rd = 8'($urandom);
            end
            hold_v = rv && !ready_in && !rf;
            hold_d = rd;
            step("rand", rv, rd, rr, rf);
            check_eq("rand.count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
        end
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
